// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty, registered read data with a
// one-cycle valid strobe, and sticky overflow/underflow error flags.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       r_en,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              rd_acc;
  logic              wr_acc;

  // Status flags decode only the registered count, so no input reaches them
  // combinationally.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // A write into a full FIFO is still legal when a read frees a slot on the
  // same edge; a read from an empty FIFO is never satisfied by a same-cycle
  // write (no read-through).
  assign rd_acc = r_en & ~empty;
  assign wr_acc = w_en & (~full | rd_acc);

  // Next occupancy: moves only when exactly one side is accepted.
  always_comb begin
    // NOTE: default assignment first so every path drives count_d; otherwise a latch is inferred.
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array: written on accepted writes only.
  // NOTE: the memory has no reset; stale entries are unreachable because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
    end
  end

  // Registered read port: data_out holds between reads, data_valid pulses
  // for the one cycle after each accepted read. When full with a simultaneous
  // read and write, rd_ptr == wr_ptr and the old word is read before the
  // write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      if (rd_acc) data_out <= mem[rd_ptr];
    end
  end

  // Sticky error flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_en & ~wr_acc) | (overflow  & ~clr_err);
      underflow <= (r_en & ~rd_acc) | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed stimulus with a read-data scoreboard. Reads
// push their hand-computed expected word; a monitor pops on data_valid.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              w_en;
  logic [DATA_W-1:0] data_in;
  logic              r_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] sb [$];

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: data_valid with data_out=%0d, expected no read data (t=%0t)",
                 data_out, $time);
      end else begin
        logic [DATA_W-1:0] exp;
        exp = sb.pop_front();
        if (data_out !== exp) begin
          n_fail++;
          $display("FAIL sb_data: got %0d, expected %0d (t=%0t)", data_out, exp, $time);
        end
      end
    end
  end

  // One clock with the given request pattern; inputs change on negedges.
  task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
    w_en = w; data_in = d; r_en = r; clr_err = c;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [DATA_W-1:0] exp);
    sb.push_back(exp);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},      32'(count), 0);
    check({tag, "_empty"},      32'(empty), 1);
    check({tag, "_full"},       32'(full), 0);
    check({tag, "_ae"},         32'(almost_empty), 1);
    check({tag, "_af"},         32'(almost_full), 0);
    check({tag, "_overflow"},   32'(overflow), 0);
    check({tag, "_underflow"},  32'(underflow), 0);
    check({tag, "_data_out"},   32'(data_out), 0);
    check({tag, "_data_valid"}, 32'(data_valid), 0);
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst");

    // 1: basic write/read ordering
    wr(8'd10); wr(8'd20); wr(8'd30); wr(8'd40);
    check("t1_count4", 32'(count), 4);
    rd(8'd10);
    check("t1_latency_valid", 32'(data_valid), 1);
    rd(8'd20); rd(8'd30); rd(8'd40);
    check("t1_count0", 32'(count), 0);
    check("t1_empty", 32'(empty), 1);
    @(negedge clk);
    check("t1_valid_drop", 32'(data_valid), 0);

    // 2: fill, almost_full/full, overflow on 17th write
    for (int i = 1; i <= 16; i++) begin
      wr(8'(i));
      if (i == 13) check("t2_af_at13", 32'(almost_full), 0);
      if (i == 14) check("t2_af_at14", 32'(almost_full), 1);
      if (i == 15) check("t2_full_at15", 32'(full), 0);
    end
    check("t2_full", 32'(full), 1);
    check("t2_count16", 32'(count), 16);
    wr(8'd200);
    check("t2_overflow", 32'(overflow), 1);
    check("t2_count_hold", 32'(count), 16);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t2_clr_overflow", 32'(overflow), 0);

    // 3: simultaneous read/write at full
    sb.push_back(8'd1);
    cycle(1'b1, 8'd99, 1'b1, 1'b0);
    check("t3_count16", 32'(count), 16);
    check("t3_full", 32'(full), 1);
    check("t3_no_overflow", 32'(overflow), 0);
    check("t3_data_out", 32'(data_out), 1);
    for (int i = 2; i <= 16; i++) rd(8'(i));
    rd(8'd99);
    check("t3_empty", 32'(empty), 1);

    // 4: underflow, clear, set-wins, no read-through
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t4_underflow", 32'(underflow), 1);
    check("t4_valid0", 32'(data_valid), 0);
    check("t4_count0", 32'(count), 0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t4_clr", 32'(underflow), 0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("t4_set_wins", 32'(underflow), 1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t4_clr2", 32'(underflow), 0);
    cycle(1'b1, 8'd7, 1'b1, 1'b0);
    check("t4_rw_count1", 32'(count), 1);
    check("t4_rw_underflow", 32'(underflow), 1);
    check("t4_rw_valid0", 32'(data_valid), 0);
    check("t4_rw_data_hold", 32'(data_out), 99);
    rd(8'd7);

    // 5: reset mid-burst wins over a concurrent write
    for (int i = 1; i <= 5; i++) wr(8'(100 + i));
    check("t5_count5", 32'(count), 5);
    rst = 1'b1;
    cycle(1'b1, 8'd250, 1'b0, 1'b0);
    rst = 1'b0;
    check_reset_state("t5");
    wr(8'd55);
    rd(8'd55);
    check("t5_data55", 32'(data_out), 55);

    // 6: threshold sweep
    check("t6_ae_c0", 32'(almost_empty), 1);
    wr(8'd1); check("t6_ae_c1", 32'(almost_empty), 1);
    wr(8'd2); check("t6_ae_c2", 32'(almost_empty), 1);
    wr(8'd3); check("t6_ae_c3", 32'(almost_empty), 0);
    for (int i = 4; i <= 13; i++) wr(8'(i));
    check("t6_af_c13", 32'(almost_full), 0);
    wr(8'd14);
    check("t6_af_c14", 32'(almost_full), 1);
    for (int i = 1; i <= 14; i++) rd(8'(i));
    check("t6_drained", 32'(empty), 1);

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
